// File: rtl/spectrum_band_accumulator.sv
`default_nettype none
// spectrum_band_accumulator: |re|+|im| per FFT bin, lower-half bins averaged into 16 clamped bands.
// Optional build macro PEAK_DECAY_EN enables peak-hold with a DECAY_STEP fall per frame. Rev 1.0
module spectrum_band_accumulator #(
    parameter int FFT_POINTS = 256,
    parameter int BAND_SHIFT = $clog2(FFT_POINTS / 32),
    parameter int MAX_OUT    = 32767,
    parameter int DECAY_STEP = 512
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        s_valid,
    input  logic        s_sop,
    input  logic        s_eop,
    input  logic [23:0] s_real,
    input  logic [23:0] s_imag,
    output logic        s_ready,
    output logic        done,
    output logic        frame_err,
    output logic [23:0] f0,
    output logic [23:0] f1,
    output logic [23:0] f2,
    output logic [23:0] f3,
    output logic [23:0] f4,
    output logic [23:0] f5,
    output logic [23:0] f6,
    output logic [23:0] f7,
    output logic [23:0] f8,
    output logic [23:0] f9,
    output logic [23:0] f10,
    output logic [23:0] f11,
    output logic [23:0] f12,
    output logic [23:0] f13,
    output logic [23:0] f14,
    output logic [23:0] f15
);

    localparam int               BIN_W     = $clog2(FFT_POINTS);
    localparam int               NBANDS    = 16;
    localparam logic [BIN_W-1:0] LAST_BIN  = BIN_W'(FFT_POINTS - 1);
    localparam logic [31:0]      MAX_OUT_W = 32'(MAX_OUT);
    localparam logic [23:0]      DECAY_W   = 24'(DECAY_STEP);
`ifdef PEAK_DECAY_EN
    localparam bit               DECAY_ON  = 1'b1;
`else
    localparam bit               DECAY_ON  = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCUM   = 2'd1,
        PUBLISH = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [BIN_W-1:0] bin_q, bin_d, w_cur_bin;
    logic             pipe_vld_q, pipe_vld_d;
    logic [3:0]       pipe_band_q, pipe_band_d;
    logic [23:0]      pipe_mag_q, pipe_mag_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic [31:0]      acc_q [NBANDS];
    logic [31:0]      acc_d [NBANDS];
    logic [23:0]      f_q   [NBANDS];
    logic [23:0]      f_d   [NBANDS];
    logic [23:0]      w_new [NBANDS];
    logic             w_accept, w_clear, w_take;
    logic [24:0]      w_abs_re, w_abs_im, w_mag_sum;
    logic [23:0]      w_mag;

    assign s_ready  = ~reset & (state_q != PUBLISH);
    assign w_accept = s_valid & s_ready;

    // 25-bit absolute values so that |-2^23| stays exact
    assign w_abs_re  = s_real[23] ? (25'd0 - {s_real[23], s_real}) : {1'b0, s_real};
    assign w_abs_im  = s_imag[23] ? (25'd0 - {s_imag[23], s_imag}) : {1'b0, s_imag};
    assign w_mag_sum = w_abs_re + w_abs_im;
    assign w_mag     = w_mag_sum[24] ? 24'hFFFFFF : w_mag_sum[23:0];

    assign pipe_vld_d  = w_take & ~w_cur_bin[BIN_W-1];
    assign pipe_band_d = w_cur_bin[BAND_SHIFT +: 4];
    assign pipe_mag_d  = w_mag;

    // The pending pipeline sample is folded in here so PUBLISH sees complete sums
    for (genvar k = 0; k < NBANDS; k++) begin : g_band
        logic [31:0] w_sum, w_avg;
        logic [23:0] w_comp, w_floor;
        assign w_sum    = acc_q[k] + ((pipe_vld_q && (pipe_band_q == 4'(k))) ? {8'd0, pipe_mag_q} : 32'd0);
        assign acc_d[k] = w_clear ? 32'd0 : w_sum;
        assign w_avg    = w_sum >> BAND_SHIFT;
        assign w_comp   = (w_avg > MAX_OUT_W) ? MAX_OUT_W[23:0] : w_avg[23:0];
        assign w_floor  = (f_q[k] > DECAY_W) ? (f_q[k] - DECAY_W) : 24'd0;
        assign w_new[k] = (DECAY_ON && (w_floor > w_comp)) ? w_floor : w_comp;
    end

    always_comb begin
        state_d   = state_q;
        bin_d     = bin_q;
        w_cur_bin = '0;
        w_clear   = 1'b0;
        w_take    = 1'b0;
        err_d     = 1'b0;
        done_d    = 1'b0;
        f_d       = f_q;
        case (state_q)
            IDLE: begin
                if (w_accept && s_sop) begin
                    if (s_eop) begin
                        err_d = 1'b1;
                    end else begin
                        w_clear = 1'b1;
                        w_take  = 1'b1;
                        bin_d   = '0;
                        state_d = ACCUM;
                    end
                end
            end
            ACCUM: begin
                if (w_accept) begin
                    if (s_sop) begin
                        err_d   = 1'b1;
                        w_clear = 1'b1;
                        if (s_eop) begin
                            state_d = IDLE;
                        end else begin
                            w_take = 1'b1;
                            bin_d  = '0;
                        end
                    end else begin
                        w_cur_bin = bin_q + BIN_W'(1);
                        w_take    = 1'b1;
                        bin_d     = w_cur_bin;
                        if (w_cur_bin == LAST_BIN) begin
                            if (s_eop) begin
                                state_d = PUBLISH;
                            end else begin
                                err_d   = 1'b1;
                                state_d = IDLE;
                            end
                        end else if (s_eop) begin
                            err_d   = 1'b1;
                            state_d = IDLE;
                        end
                    end
                end
            end
            PUBLISH: begin
                done_d  = 1'b1;
                f_d     = w_new;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            bin_q       <= '0;
            pipe_vld_q  <= 1'b0;
            pipe_band_q <= '0;
            pipe_mag_q  <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            for (int k = 0; k < NBANDS; k++) begin
                acc_q[k] <= '0;
                f_q[k]   <= '0;
            end
        end else begin
            state_q     <= state_d;
            bin_q       <= bin_d;
            pipe_vld_q  <= pipe_vld_d;
            pipe_band_q <= pipe_band_d;
            pipe_mag_q  <= pipe_mag_d;
            done_q      <= done_d;
            err_q       <= err_d;
            for (int k = 0; k < NBANDS; k++) begin
                acc_q[k] <= acc_d[k];
                f_q[k]   <= f_d[k];
            end
        end
    end

    assign done      = done_q;
    assign frame_err = err_q;
    assign f0  = f_q[0];
    assign f1  = f_q[1];
    assign f2  = f_q[2];
    assign f3  = f_q[3];
    assign f4  = f_q[4];
    assign f5  = f_q[5];
    assign f6  = f_q[6];
    assign f7  = f_q[7];
    assign f8  = f_q[8];
    assign f9  = f_q[9];
    assign f10 = f_q[10];
    assign f11 = f_q[11];
    assign f12 = f_q[12];
    assign f13 = f_q[13];
    assign f14 = f_q[14];
    assign f15 = f_q[15];

endmodule
`default_nettype wire
